// File: rtl/inv_sched.sv
// rtl/inv_sched.sv - column-by-column inverse sequencer driving forward/backward substitution
module inv_sched #(
    parameter int N       = 4,
    parameter int FRAC    = 14,
    parameter int TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                abort,
    input  logic [N*N*32-1:0]   L_in,
    input  logic [N*N*32-1:0]   U_in,
    output logic                fwd_start,
    output logic [N*N*32-1:0]   fwd_L,
    output logic [N*32-1:0]     fwd_b,
    input  logic                fwd_done,
    input  logic [N*32-1:0]     fwd_y,
    output logic                bwd_start,
    output logic [N*N*32-1:0]   bwd_U,
    output logic [N*32-1:0]     bwd_y,
    input  logic                bwd_done,
    input  logic [N*32-1:0]     bwd_x,
    output logic                busy,
    output logic [1:0]          col,
    output logic [N*N*32-1:0]   inv_out,
    output logic                done,
    output logic                err
);
    localparam logic [31:0] ONE = 32'd1 << FRAC;

    typedef enum logic [2:0] {
        IDLE, FWD_GO, FWD_WAIT, BWD_GO, BWD_WAIT, STORE, FIN, ERR
    } state_t;

    state_t              state_q, state_d;
    logic [1:0]          col_q, col_d;
    logic [N*32-1:0]     y_q, y_d;
    logic [N*N*32-1:0]   inv_q, inv_d;
    logic                err_q, err_d;
    logic [7:0]          wdog_q, wdog_d;
    logic                fdone_q, bdone_q;
    logic                fwd_edge, bwd_edge;

    // Only a fresh rising edge counts, so sticky-level done from an earlier job is ignored.
    assign fwd_edge = fwd_done & ~fdone_q;
    assign bwd_edge = bwd_done & ~bdone_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            col_q   <= '0;
            y_q     <= '0;
            inv_q   <= '0;
            err_q   <= 1'b0;
            wdog_q  <= '0;
            fdone_q <= 1'b0;
            bdone_q <= 1'b0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            y_q     <= y_d;
            inv_q   <= inv_d;
            err_q   <= err_d;
            wdog_q  <= wdog_d;
            fdone_q <= fwd_done;
            bdone_q <= bwd_done;
        end
    end

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        y_d     = y_q;
        inv_d   = inv_q;
        err_d   = err_q;
        wdog_d  = wdog_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = FWD_GO;
                    col_d   = '0;
                    err_d   = 1'b0;
                end
            end
            FWD_GO: begin
                state_d = FWD_WAIT;
                wdog_d  = '0;
            end
            FWD_WAIT: begin
                if (fwd_edge) begin
                    y_d     = fwd_y;
                    state_d = BWD_GO;
                end else if (wdog_q == 8'(TIMEOUT)) begin
                    state_d = ERR;
                    err_d   = 1'b1;
                end else begin
                    wdog_d = wdog_q + 8'd1;
                end
            end
            BWD_GO: begin
                state_d = BWD_WAIT;
                wdog_d  = '0;
            end
            BWD_WAIT: begin
                if (bwd_edge) begin
                    for (int r = 0; r < N; r++)
                        inv_d[(r*N + int'(col_q))*32 +: 32] = bwd_x[r*32 +: 32];
                    state_d = STORE;
                end else if (wdog_q == 8'(TIMEOUT)) begin
                    state_d = ERR;
                    err_d   = 1'b1;
                end else begin
                    wdog_d = wdog_q + 8'd1;
                end
            end
            STORE: begin
                if (col_q == 2'(N-1)) begin
                    state_d = FIN;
                end else begin
                    col_d   = col_q + 2'd1;
                    state_d = FWD_GO;
                end
            end
            FIN:     state_d = IDLE;
            ERR:     state_d = ERR;
            default: state_d = IDLE;
        endcase
        // Abort overrides every transition above, including start in IDLE; inv_out keeps partial columns.
        if (abort) begin
            state_d = IDLE;
            if (state_q != IDLE) begin
                col_d = '0;
                y_d   = '0;
            end
        end
    end

    always_comb begin
        fwd_b = '0;
        if (state_q == FWD_GO || state_q == FWD_WAIT)
            fwd_b[int'(col_q)*32 +: 32] = ONE;
    end

    assign fwd_start = (state_q == FWD_GO);
    assign bwd_start = (state_q == BWD_GO);
    assign busy      = (state_q != IDLE);
    assign done      = (state_q == FIN);
    assign fwd_L     = L_in;
    assign bwd_U     = U_in;
    assign bwd_y     = y_q;
    assign col       = col_q;
    assign inv_out   = inv_q;
    assign err       = err_q;
endmodule

// File: tb/tb_inv_sched.sv
// tb/tb_inv_sched.sv - directed self-checking bench for inv_sched with substitution stubs
module tb_inv_sched;
    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start = 1'b0;
    logic         abort = 1'b0;
    logic [511:0] L_in, U_in;
    logic         fwd_start, bwd_start, busy, done, err;
    logic [511:0] fwd_L, bwd_U, inv_out;
    logic [127:0] fwd_b, bwd_y;
    logic         fwd_done = 1'b0, bwd_done = 1'b0;
    logic [127:0] fwd_y = '0, bwd_x = '0;
    logic [1:0]   col;

    int checks = 0;
    int failures = 0;

    int fd_cfg = 3, bd_cfg = 3, never_col = -1;
    bit sticky = 1'b0;
    int fcnt = 0, bcnt = 0;

    inv_sched dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .L_in(L_in), .U_in(U_in),
        .fwd_start(fwd_start), .fwd_L(fwd_L), .fwd_b(fwd_b),
        .fwd_done(fwd_done), .fwd_y(fwd_y),
        .bwd_start(bwd_start), .bwd_U(bwd_U), .bwd_y(bwd_y),
        .bwd_done(bwd_done), .bwd_x(bwd_x),
        .busy(busy), .col(col), .inv_out(inv_out), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    // Forward stub: fwd_y = b, done after fd_cfg cycles (pulse or sticky level).
    always @(negedge clk) begin
        if (fwd_start) begin
            fwd_done = 1'b0;
            fcnt = fd_cfg;
        end else if (fcnt > 0) begin
            fcnt = fcnt - 1;
            if (fcnt == 0) begin
                fwd_done = 1'b1;
                fwd_y = fwd_b;
            end
        end else if (!sticky) begin
            fwd_done = 1'b0;
        end
    end

    // Backward stub: x[r] = y[r] + r; never answers on column never_col.
    always @(negedge clk) begin
        if (bwd_start) begin
            bwd_done = 1'b0;
            bcnt = (int'(col) == never_col) ? 0 : bd_cfg;
        end else if (bcnt > 0) begin
            bcnt = bcnt - 1;
            if (bcnt == 0) begin
                bwd_done = 1'b1;
                for (int r = 0; r < 4; r++)
                    bwd_x[r*32 +: 32] = bwd_y[r*32 +: 32] + 32'(r);
            end
        end else if (!sticky) begin
            bwd_done = 1'b0;
        end
    end

    task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [127:0] ev(input int i);
        logic [127:0] v;
        v = '0;
        v[i*32 +: 32] = 32'd16384;
        return v;
    endfunction

    function automatic logic [511:0] exp_inv();
        logic [511:0] m;
        m = '0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                m[(r*4+c)*32 +: 32] = (r == c ? 32'd16384 : 32'd0) + 32'(r);
        return m;
    endfunction

    task automatic check_all_zero(input string nm);
        chk({nm, "_ctl"}, 512'({busy, col, done, err, fwd_start, bwd_start}), 512'd0);
        chk({nm, "_fwd_b"}, 512'(fwd_b), 512'd0);
        chk({nm, "_bwd_y"}, 512'(bwd_y), 512'd0);
        chk({nm, "_inv"}, inv_out, 512'd0);
    endtask

    typedef struct {
        int fd;
        int bd;
        bit sticky;
        bit spam;
        int exp_cyc;
    } vec_t;

    task automatic run_case(input string nm, input vec_t v);
        int  cyc, done_cyc, ndone, nfs, nbs;
        bit  seq_ok;
        fd_cfg = v.fd; bd_cfg = v.bd; sticky = v.sticky; never_col = -1;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        cyc = 1; done_cyc = -1; ndone = 0; nfs = 0; nbs = 0; seq_ok = 1'b1;
        chk({nm, "_err_clr"}, 512'(err), 512'd0);
        while (cyc < 4000 && !(ndone > 0 && cyc > done_cyc + 3)) begin
            if (fwd_start) begin
                if (nfs < 4 && fwd_b !== ev(nfs)) seq_ok = 1'b0;
                nfs++;
            end
            if (bwd_start) begin
                if (nbs < 4 && bwd_y !== ev(nbs)) seq_ok = 1'b0;
                nbs++;
            end
            if (done) begin
                ndone++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            start = v.spam && (cyc % 5 == 0) && (cyc < v.exp_cyc - 3);
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        chk({nm, "_done_cyc"}, 512'(done_cyc), 512'(v.exp_cyc));
        chk({nm, "_done_cnt"}, 512'(ndone), 512'd1);
        chk({nm, "_fwd_starts"}, 512'(nfs), 512'd4);
        chk({nm, "_bwd_starts"}, 512'(nbs), 512'd4);
        chk({nm, "_b_y_seq"}, 512'(seq_ok), 512'd1);
        chk({nm, "_inv"}, inv_out, exp_inv());
        chk({nm, "_err"}, 512'(err), 512'd0);
        chk({nm, "_idle"}, 512'(busy), 512'd0);
    endtask

    vec_t tbl [6];

    initial begin
        int cyc, ndone, nfs, err_cyc;
        tbl[0] = '{fd: 3,   bd: 3,   sticky: 1'b0, spam: 1'b0, exp_cyc: 37};
        tbl[1] = '{fd: 3,   bd: 3,   sticky: 1'b1, spam: 1'b0, exp_cyc: 37};
        tbl[2] = '{fd: 1,   bd: 1,   sticky: 1'b0, spam: 1'b0, exp_cyc: 21};
        tbl[3] = '{fd: 256, bd: 3,   sticky: 1'b0, spam: 1'b0, exp_cyc: 1049};
        tbl[4] = '{fd: 3,   bd: 256, sticky: 1'b1, spam: 1'b0, exp_cyc: 1049};
        tbl[5] = '{fd: 2,   bd: 4,   sticky: 1'b0, spam: 1'b1, exp_cyc: 37};

        for (int i = 0; i < 16; i++) begin
            L_in[i*32 +: 32] = 32'h1000_0000 + 32'(i * 7);
            U_in[i*32 +: 32] = 32'h2000_0000 + 32'(i * 13);
        end

        #12;
        check_all_zero("reset");
        chk("fwd_L_pass", fwd_L, L_in);
        chk("bwd_U_pass", bwd_U, U_in);
        @(negedge clk); rst = 1'b1;

        // start and abort together in IDLE: abort wins
        @(negedge clk); start = 1'b1; abort = 1'b1;
        @(negedge clk); start = 1'b0; abort = 1'b0;
        chk("start_abort_idle", 512'(busy), 512'd0);

        for (int i = 0; i < 6; i++)
            run_case($sformatf("vec%0d", i), tbl[i]);

        // abort mid FWD_WAIT of column 1, with a stray start while busy
        fd_cfg = 3; bd_cfg = 3; sticky = 1'b0; never_col = -1;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        nfs = 0;
        for (cyc = 1; cyc < 11; cyc++) begin
            if (fwd_start) nfs++;
            start = (cyc == 3);
            @(negedge clk);
        end
        start = 1'b0;
        chk("abort_pre_col", 512'(col), 512'd1);
        chk("abort_pre_fs", 512'(nfs), 512'd2);
        abort = 1'b1;
        @(negedge clk); abort = 1'b0;
        chk("abort_busy", 512'(busy), 512'd0);
        chk("abort_col", 512'(col), 512'd0);
        chk("abort_bwd_y", 512'(bwd_y), 512'd0);
        ndone = 0; nfs = 0;
        for (int k = 0; k < 20; k++) begin
            if (done) ndone++;
            if (fwd_start) nfs++;
            @(negedge clk);
        end
        chk("abort_no_done", 512'(ndone), 512'd0);
        chk("abort_no_restart", 512'(nfs), 512'd0);

        // watchdog: backward stub silent on column 2
        never_col = 2;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        cyc = 1; ndone = 0; err_cyc = -1;
        while (cyc < 400 && err_cyc < 0) begin
            if (done) ndone++;
            if (err) err_cyc = cyc;
            else begin
                @(negedge clk);
                cyc++;
            end
        end
        chk("wdog_err_cyc", 512'(err_cyc), 512'd280);
        chk("wdog_no_done", 512'(ndone), 512'd0);
        chk("wdog_busy", 512'(busy), 512'd1);
        start = 1'b1;
        @(negedge clk); start = 1'b0;
        nfs = 0;
        for (int k = 0; k < 5; k++) begin
            if (fwd_start) nfs++;
            @(negedge clk);
        end
        chk("err_start_ignored", 512'(nfs), 512'd0);
        chk("err_hold", 512'({busy, err}), 512'd3);
        abort = 1'b1;
        @(negedge clk); abort = 1'b0;
        chk("err_abort", 512'({busy, err}), 512'd1);
        run_case("after_err", tbl[0]);

        // async reset in BWD_WAIT of column 3
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        for (cyc = 1; cyc < 34; cyc++) @(negedge clk);
        chk("prerst_col", 512'(col), 512'd3);
        chk("prerst_busy", 512'(busy), 512'd1);
        rst = 1'b0;
        #1;
        check_all_zero("async_rst");
        @(negedge clk); rst = 1'b1;
        @(negedge clk);
        run_case("after_rst", tbl[0]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
